// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_PREP = 2'b01,
        MD_RUN  = 2'b10,
        MD_FIX  = 2'b11
    } md_state_e;

    localparam int         MD_ITER     = 32;
    localparam logic [4:0] MD_CNT_LOAD = 5'(MD_ITER - 1);

    function automatic logic [31:0] md_neg32(input logic [31:0] v, input logic en);
        if (en) begin
            md_neg32 = 32'd0 - v;
        end else begin
            md_neg32 = v;
        end
    endfunction

    function automatic logic [63:0] md_neg64(input logic [63:0] v, input logic en);
        if (en) begin
            md_neg64 = 64'd0 - v;
        end else begin
            md_neg64 = v;
        end
    endfunction

    // Magnitude for signed ops; unsigned operands pass through untouched.
    function automatic logic [31:0] md_abs32(input logic [31:0] v, input logic sgn);
        md_abs32 = md_neg32(v, sgn & v[31]);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side bundle of the multiply/divide unit: command, HI/LO access and status.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output start, op, a, b, we_hi, we_lo, wd, rd_hilo,
        input  hi, lo, busy, stall, done
    );

    modport slave (
        input  start, op, a, b, we_hi, we_lo, wd, rd_hilo,
        output hi, lo, busy, stall, done
    );
endinterface

// File: rtl/muldiv_unit_md_step.sv
// One iteration of the datapath: shift-add multiply (LSB first) or
// restoring divide (MSB first). i_x is the shifting operand, i_y the fixed one.
module md_step (
    input  logic        i_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [63:0] o_acc,
    output logic [31:0] o_x
);
    logic [32:0] w_sum;
    logic [32:0] w_part;
    logic [31:0] w_diff;
    logic        w_ge;

    // Both candidate results are formed, op selects which one is kept.
    always_comb begin
        w_sum  = {1'b0, i_acc[63:32]} + (i_x[0] ? {1'b0, i_y} : 33'd0);
        w_part = {i_acc[63:32], i_x[31]};
        w_ge   = (w_part >= {1'b0, i_y});
        w_diff = w_part[31:0] - i_y;
        if (i_div) begin
            o_x = {i_x[30:0], 1'b0};
            if (w_ge) begin
                o_acc = {w_diff, i_acc[30:0], 1'b1};
            end else begin
                o_acc = {w_part[31:0], i_acc[30:0], 1'b0};
            end
        end else begin
            o_x   = {1'b0, i_x[31:1]};
            o_acc = {w_sum, i_acc[31:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO pair
// and stalls the core while an operation is in flight.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave md_if
);
    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_x;
    logic [31:0] r_y;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [63:0] w_acc_nxt;
    logic [31:0] w_x_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_busy;
    logic        w_stall;
    logic        w_done;

    assign w_signed = ~r_op[0];

    md_step u_step (
        .i_div (r_op[1]),
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_y   (r_y),
        .o_acc (w_acc_nxt),
        .o_x   (w_x_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: begin
                if (md_if.start) begin
                    w_state_nxt = MD_PREP;
                end else begin
                    w_state_nxt = MD_IDLE;
                end
            end
            MD_PREP: w_state_nxt = MD_RUN;
            MD_RUN: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = MD_FIX;
                end else begin
                    w_state_nxt = MD_RUN;
                end
            end
            MD_FIX:  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Status outputs; stall only affects instructions that touch the unit.
    always_comb begin
        w_busy  = (r_state != MD_IDLE);
        w_done  = (r_state == MD_FIX);
        w_stall = w_busy & (md_if.start | md_if.rd_hilo | md_if.we_hi | md_if.we_lo);
    end

    // Operand latch, sign preprocessing and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 2'b00;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_x       <= 32'd0;
            r_y       <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (md_if.start) begin
                        r_op <= md_if.op;
                        r_a  <= md_if.a;
                        r_b  <= md_if.b;
                    end
                end
                MD_PREP: begin
                    // Multiply shifts the multiplier (b); divide shifts the dividend (a).
                    r_x       <= r_op[1] ? md_abs32(r_a, w_signed) : md_abs32(r_b, w_signed);
                    r_y       <= r_op[1] ? md_abs32(r_b, w_signed) : md_abs32(r_a, w_signed);
                    r_neg_res <= w_signed & (r_a[31] ^ r_b[31]);
                    r_neg_rem <= w_signed & r_a[31];
                    r_acc     <= 64'd0;
                    r_cnt     <= MD_CNT_LOAD;
                end
                MD_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_x   <= w_x_nxt;
                    r_cnt <= r_cnt - 5'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Sign fix-up of the final result; divide by zero bypasses the datapath.
    always_comb begin
        w_prod = md_neg64(r_acc, r_neg_res);
        if (!r_op[1]) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else if (r_b == 32'd0) begin
            w_res_hi = r_a;
            w_res_lo = 32'hFFFF_FFFF;
        end else begin
            w_res_hi = md_neg32(r_acc[63:32], r_neg_rem);
            w_res_lo = md_neg32(r_acc[31:0], r_neg_res);
        end
    end

    // HI/LO: moves only in IDLE without a start, results at the end of FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (r_state == MD_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if ((r_state == MD_IDLE) && !md_if.start) begin
            if (md_if.we_hi) begin
                r_hi <= md_if.wd;
            end
            if (md_if.we_lo) begin
                r_lo <= md_if.wd;
            end
        end
    end

    assign md_if.hi    = r_hi;
    assign md_if.lo    = r_lo;
    assign md_if.busy  = w_busy;
    assign md_if.stall = w_stall;
    assign md_if.done  = w_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, HI/LO moves,
// stall behaviour, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op for a single cycle, then observes 35 falling edges.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          output int busy_n, output int done_n, output int done_at);
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                done_n++;
                done_at = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.we_hi   = 1'b0;
        bus.we_lo   = 1'b0;
        bus.wd      = 32'd0;
        bus.rd_hilo = 1'b0;
        #12;
        n_checks++;
        if ({bus.hi, bus.lo} !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
        end
        n_checks++;
        if ({bus.busy, bus.stall, bus.done} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.stall, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        logic [1:0]  v_op [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [31:0] v_a  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] v_b  [6] = '{32'h00000003, 32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] v_hi [6] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'h40000000};
        logic [31:0] v_lo [6] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFEB, 32'h00000001, 32'h00000001, 32'h00000000};
        int bn, dn, da;
        for (int k = 0; k < 6; k++) begin
            run_op(v_op[k], v_a[k], v_b[k], bn, dn, da);
            n_checks++;
            if ({bus.hi, bus.lo} !== {v_hi[k], v_lo[k]}) begin
                n_errors++;
                $display("FAIL mult[%0d]: got %h_%h expected %h_%h", k, bus.hi, bus.lo, v_hi[k], v_lo[k]);
            end
            n_checks++;
            if (bn !== 34 || dn !== 1 || da !== 34) begin
                n_errors++;
                $display("FAIL mult_timing[%0d]: got busy=%0d done=%0d at %0d expected 34 1 34", k, bn, dn, da);
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]  v_op [7] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        logic [31:0] v_a  [7] = '{32'hFFFFFFF9, 32'd100, 32'hFFFFFFFB, 32'h80000000, 32'd7, 32'd100, 32'hFFFFFFF9};
        logic [31:0] v_b  [7] = '{32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'd2};
        logic [31:0] v_hi [7] = '{32'hFFFFFFFF, 32'h00000064, 32'hFFFFFFFB, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000001};
        logic [31:0] v_lo [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'h0000000E, 32'h7FFFFFFC};
        int bn, dn, da;
        for (int k = 0; k < 7; k++) begin
            run_op(v_op[k], v_a[k], v_b[k], bn, dn, da);
            n_checks++;
            if ({bus.hi, bus.lo} !== {v_hi[k], v_lo[k]}) begin
                n_errors++;
                $display("FAIL div[%0d]: got %h_%h expected %h_%h", k, bus.hi, bus.lo, v_hi[k], v_lo[k]);
            end
            n_checks++;
            if (dn !== 1 || da !== 34) begin
                n_errors++;
                $display("FAIL div_done[%0d]: got %0d pulses at %0d expected 1 at 34", k, dn, da);
            end
        end
    endtask

    task automatic test_hilo_write();
        @(negedge clk);
        bus.we_lo = 1'b1;
        bus.wd    = 32'h12345678;
        @(posedge clk);
        #1;
        bus.we_lo = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.lo !== 32'h12345678) begin
            n_errors++;
            $display("FAIL mtlo: got %h expected 12345678", bus.lo);
        end
        bus.we_hi = 1'b1;
        bus.wd    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.we_hi = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.hi, bus.lo} !== {32'hCAFEF00D, 32'h12345678}) begin
            n_errors++;
            $display("FAIL mthi: got %h_%h expected cafef00d_12345678", bus.hi, bus.lo);
        end
    endtask

    task automatic test_start_priority();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.we_hi = 1'b1;
        bus.wd    = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.we_hi = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.hi !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL start_beats_mthi: got %h expected cafef00d", bus.hi);
        end
        bus.we_hi = 1'b1;
        bus.wd    = 32'h11111111;
        for (int i = 2; i <= 35; i++) begin
            @(negedge clk);
            if (i <= 5) begin
                n_checks++;
                if (bus.stall !== 1'b1) begin
                    n_errors++;
                    $display("FAIL mthi_busy_stall[%0d]: got %b expected 1", i, bus.stall);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (bus.hi !== 32'hCAFEF00D) begin
                    n_errors++;
                    $display("FAIL mthi_busy_ignored: got %h expected cafef00d", bus.hi);
                end
                bus.we_hi = 1'b0;
            end
        end
        n_checks++;
        if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin
            n_errors++;
            $display("FAIL priority_result: got %h_%h expected 0_6", bus.hi, bus.lo);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hFFFFFFFF;
        bus.b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.rd_hilo = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.stall !== (i <= 34)) begin
                n_errors++;
                $display("FAIL mfhi_stall[%0d]: got %b expected %b", i, bus.stall, (i <= 34));
            end
        end
        n_checks++;
        if (bus.hi !== 32'hFFFFFFFE) begin
            n_errors++;
            $display("FAIL mfhi_value: got %h expected fffffffe", bus.hi);
        end
        bus.rd_hilo = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.stall !== 1'b0) begin
                n_errors++;
                $display("FAIL unrelated_stall[%0d]: got %b expected 0", i, bus.stall);
            end
            if (i == 5) begin
                n_checks++;
                if (bus.busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL busy_mid: got %b expected 1", bus.busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (35) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'd2, 32'd14}) begin
            n_errors++;
            $display("FAIL b2b_first: got %b %h_%h expected 0 2_e", bus.busy, bus.hi, bus.lo);
        end
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_launch: got %b expected 1", bus.busy);
        end
        repeat (34) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.hi, bus.lo} !== {1'b0, 32'd0, 32'd81}) begin
            n_errors++;
            $display("FAIL b2b_second: got %b %h_%h expected 0 0_51", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        int bn, dn, da;
        int pulses;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hFFFFFFFF;
        bus.b     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        bus.rd_hilo = 1'b1;
        #1;
        n_checks++;
        if (bus.stall !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_stall: got %b expected 1", bus.stall);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.stall, bus.done} !== 67'd0) begin
            n_errors++;
            $display("FAIL mid_reset: got %h_%h %b%b%b expected all 0", bus.hi, bus.lo, bus.busy, bus.stall, bus.done);
        end
        bus.rd_hilo = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_done: got %0d pulses busy=%b expected 0 0", pulses, bus.busy);
        end
        run_op(2'b00, 32'hFFFFFFFE, 32'd3, bn, dn, da);
        n_checks++;
        if ({bus.hi, bus.lo} !== {32'hFFFFFFFF, 32'hFFFFFFFA} || dn !== 1) begin
            n_errors++;
            $display("FAIL after_reset_op: got %h_%h done=%0d expected ffffffff_fffffffa 1", bus.hi, bus.lo, dn);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_hilo_write();
        test_start_priority();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
